// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit opcodes, the canonical NOP word and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam logic [6:0] OP_LD   = 7'b0000000;
  localparam logic [6:0] OP_ST   = 7'b0000100;
  localparam logic [6:0] OP_ADD  = 7'b0001000;
  localparam logic [6:0] OP_SUB  = 7'b0001100;
  localparam logic [6:0] OP_AND  = 7'b0010000;
  localparam logic [6:0] OP_OR   = 7'b0010100;
  localparam logic [6:0] OP_XOR  = 7'b0011000;
  localparam logic [6:0] OP_SLT  = 7'b0011100;
  localparam logic [6:0] OP_ADDI = 7'b0100000;
  localparam logic [6:0] OP_SLL  = 7'b0100100;
  localparam logic [6:0] OP_SRL  = 7'b0101000;
  localparam logic [6:0] OP_BEQ  = 7'b0101100;
  localparam logic [6:0] OP_BNE  = 7'b0110000;
  localparam logic [6:0] OP_JMP  = 7'b0110100;
  localparam logic [6:0] OP_LUI  = 7'b0111000;

  // ADD r0,r0,r0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0008;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    VALID   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC mux: redirect (word-aligned) beats sequential advance beats hold.
// The increment wraps modulo 2^PC_WIDTH.
module pc_next_sel #(
  parameter int PC_WIDTH = 16,
  parameter int PC_STEP  = 4
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                advance,
  output logic [PC_WIDTH-1:0] pc_next
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

  always_comb begin
    pc_next = pc;
    if (branch_taken)
      pc_next = branch_target & ALIGN_MASK;
    else if (advance)
      pc_next = pc + STEP;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the imem req/ack handshake
// and hands one instruction at a time downstream with a valid/stall handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stall,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [PC_WIDTH-1:0] pc_out
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic                advance;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign advance = (state == FETCH) && imem_ack;

  pc_next_sel #(
    .PC_WIDTH (PC_WIDTH),
    .PC_STEP  (PC_STEP)
  ) u_pc_next_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (advance),
    .pc_next       (pc_next)
  );

  // imem_addr is loaded from pc_next whenever a request is launched, so it
  // always equals the registered pc while FETCH holds the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      pc_out      <= RESET_PC;
    end else begin
      pc <= pc_next;
      if (branch_taken) instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc_next;
        end
        FETCH: begin
          if (branch_taken) begin
            if (imem_ack) begin
              imem_addr <= pc_next;
            end else begin
              state    <= DISCARD;
              imem_req <= 1'b0;
            end
          end else if (imem_ack) begin
            state       <= VALID;
            imem_req    <= 1'b0;
            instr       <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (branch_taken || !stall) begin
            state       <= FETCH;
            imem_req    <= 1'b1;
            imem_addr   <= pc_next;
            instr_valid <= 1'b0;
          end
        end
        DISCARD: begin
          // A redirect here only moves pc; the pending ack still has to be
          // absorbed, otherwise a coincident ack would strand the FSM.
          if (imem_ack) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc_next;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
